// File: rtl/vx_ibuffer_rr.sv
// vx_ibuffer_rr: per-warp instruction FIFOs, round-robin arbiter and
// a registered output stage feeding dispatch.
module vx_ibuffer_rr #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH = 2,
  parameter int DATAW = 128,
  localparam int NW_BITS = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [NW_BITS-1:0]   in_wid,
  input  logic [DATAW-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [NW_BITS-1:0]   out_wid,
  output logic [DATAW-1:0]     out_data,
  input  logic                 out_ready,
  input  logic                 flush_valid,
  input  logic [NW_BITS-1:0]   flush_wid,
  output logic [NUM_WARPS-1:0] warp_full,
  output logic [NUM_WARPS-1:0] warp_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATAW-1:0]     mem [NUM_WARPS][DEPTH];
  logic [PW-1:0]        wr_ptr [NUM_WARPS];
  logic [PW-1:0]        rd_ptr [NUM_WARPS];
  logic [NW_BITS-1:0]   rr_ptr;
  logic [NUM_WARPS-1:0] elig;
  logic [NW_BITS-1:0]   win;
  logic [NW_BITS-1:0]   idx;
  logic                 found;
  logic                 push;
  logic                 pop;
  logic                 kill;
  logic                 load_en;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      warp_full[w]  = (wr_ptr[w] - rd_ptr[w]) == PW'(DEPTH);
      warp_empty[w] = wr_ptr[w] == rd_ptr[w];
      elig[w] = !warp_empty[w] &&
                !(flush_valid && flush_wid == NW_BITS'(w));
    end
  end

  assign in_ready = !warp_full[in_wid] &&
                    !(flush_valid && flush_wid == in_wid);
  assign push = in_valid && in_ready;

  // A stalled output belonging to the flushed warp is dropped.
  assign kill = flush_valid && out_valid &&
                flush_wid == out_wid && !out_ready;
  assign load_en = !out_valid || out_ready || kill;

  // rr_ptr holds the first warp to consider (last grant + 1).
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      idx = rr_ptr + NW_BITS'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign pop = load_en && found;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        wr_ptr[w] <= '0;
        rd_ptr[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (flush_valid && flush_wid == NW_BITS'(w)) begin
          rd_ptr[w] <= wr_ptr[w];
        end else begin
          if (push && in_wid == NW_BITS'(w))
            wr_ptr[w] <= wr_ptr[w] + 1'b1;
          if (pop && win == NW_BITS'(w))
            rd_ptr[w] <= rd_ptr[w] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[in_wid][wr_ptr[in_wid][AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_wid   <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      out_valid <= found;
      if (found) begin
        out_wid  <= win;
        out_data <= mem[win][rd_ptr[win][AW-1:0]];
        rr_ptr   <= win + 1'b1;
      end
    end
  end

endmodule

// File: doc/vx_ibuffer_rr.md
Name: vx_ibuffer_rr

Overview:
Per-warp instruction buffer sitting between decode and dispatch. Decoded instructions, tagged with a warp id, are pushed into one FIFO per warp. A round-robin arbiter picks among non-empty warps and loads one instruction per cycle into a registered output stage that drives the dispatch stage's instruction valid/ready interface. Per-warp full/empty flags go to the warp scheduler, and a per-warp flush discards a warp's queued instructions.

Parameters:
NUM_WARPS, 4, number of warps; power of 2, at least 2.
DEPTH, 2, entries per warp FIFO; power of 2, at least 2.
DATAW, 128, width of the opaque decoded-instruction payload (uuid, tmask, PC, ex_type, op_type, op_mod, imm, rd, rs*, flags).
NW_BITS, clog2(NUM_WARPS), derived; not overridden.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset; asserted when 0.
in_valid  in  1  decode has an instruction.
in_wid  in  NW_BITS  target warp of the incoming instruction.
in_data  in  DATAW  decoded instruction payload.
in_ready  out  1  buffer accepts the push this cycle.
out_valid  out  1  registered output holds an instruction.
out_wid  out  NW_BITS  warp of the output instruction.
out_data  out  DATAW  payload of the output instruction.
out_ready  in  1  dispatch consumes the output this cycle.
flush_valid  in  1  discard all instructions of flush_wid.
flush_wid  in  NW_BITS  warp to flush.
warp_full  out  NUM_WARPS  bit w = FIFO w holds DEPTH entries.
warp_empty  out  NUM_WARPS  bit w = FIFO w holds 0 entries.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low.
- Reset (reset=0, takes effect immediately without waiting for a clock edge):
  - All FIFO pointers and counts are 0.
  - out_valid=0, out_wid=0, out_data=0.
  - warp_empty all 1, warp_full all 0.
  - Round-robin pointer is 0, so warp 0 has first priority.
- FIFOs:
  - Each FIFO is circular, with read/write pointers of clog2(DEPTH)+1 bits; wrap-around is handled by the extra MSB.
  - full = (count==DEPTH); empty = (count==0).
  - warp_full and warp_empty derive only from registered counts.
- Push:
  - in_ready = !warp_full[in_wid] && !(flush_valid && flush_wid==in_wid). It is combinational from in_wid.
  - A pop in the same cycle does not free space for a push; there is no full-FIFO pass-through.
  - A push occurs when in_valid && in_ready. Entries written at edge N are visible (non-empty) from cycle N+1.
- Output register:
  - load_en = !out_valid || out_ready || kill.
  - kill = flush_valid && out_valid && flush_wid==out_wid && !out_ready.
  - If load_en is set, the output register loads the round-robin winner and pops that warp's FIFO. The winner is chosen among non-empty warps, excluding flush_wid when flush_valid.
  - If no warp is eligible, out_valid becomes 0.
- Latency: minimum 2 cycles. A push at edge N makes the instruction eligible in cycle N+1, and out_valid rises after edge N+1. Throughput is 1 instruction per cycle.
- Round robin: search starts at (last_grant+1) mod NUM_WARPS; the pointer updates only on a grant. A warp that is continuously non-empty is served within NUM_WARPS grants.
- Ordering: FIFO order within a warp; no ordering guarantee across warps.
- Stall rule: while out_valid && !out_ready, out_wid and out_data hold stable. The sole exception is kill.
- Flush:
  - On the edge with flush_valid, FIFO flush_wid is emptied (pointers equalised).
  - If the output register holds that warp and out_ready=0, the entry is dropped. If out_ready=1 in the same cycle, the handshake completes normally.
  - A push to the flushed warp in the flush cycle is refused (in_ready=0).
- Simultaneous push and pop on the same non-full warp: count is unchanged and both operations complete.

Test Plan:
1. Release reset; push warp 0 data 0xA1 at edge 0, out_ready=1 → out_valid=1 with out_wid=0, out_data=0xA1 after edge 1; warp_empty=4'b1111 from cycle 2.
2. DEPTH=2, out_ready=0; push 0xB0, 0xB1, 0xB2 to warp 1 → out_data=0xB0 holds; warp_full[1]=1; a 4th push sees in_ready=0. One out_ready pulse → out_data=0xB1 and warp_full[1]=0 next cycle.
3. Warps 0, 1, 2 each hold 2 entries, out_ready=1 constantly → out_wid sequence is 0,1,2,0,1,2, then out_valid=0.
4. Output holds warp 2 (out_ready=0), warp 2 FIFO holds 1 entry, warp 3 holds 0xD3; pulse flush_valid with flush_wid=2 → next cycle out_wid=3, out_data=0xD3, warp_empty[2]=1.
5. Same-cycle flush_valid (flush_wid=0) and in_valid (in_wid=0) → in_ready=0; warp 0 remains empty.
6. Assert reset=0 mid-cycle while 3 warps hold data → out_valid=0 and warp_empty all 1 before the next edge; after release, the first grant goes to warp 0.
